// File: rtl/pingpang_pkg.sv
// Shared fill-mode encodings and small width/slice helpers for the pang shift pipeline.
// Pure declarations: no latency, no backpressure.
package pingpang_pkg;

  localparam logic [1:0] FILL_ZERO = 2'b00;
  localparam logic [1:0] FILL_ROT  = 2'b01;
  localparam logic [1:0] FILL_PREV = 2'b10;

  // Shift width and pipeline depth for a given lane count.
  function automatic int sw_of(input int lanes);
    return (lanes < 2) ? 1 : $clog2(lanes);
  endfunction

  // Bit offset of a lane inside a flat lane vector.
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/pingpang_shift_pipe_if.sv
// Beat-level handshake bundle for the pang shift pipeline: input side and output side.
// Wires only: no latency; backpressure carried by in_ready/out_ready.
interface pingpang_shift_pipe_if
  import pingpang_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DW    = 8,
  localparam int SW   = sw_of(LANES)
);

  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic [SW-1:0]       in_sft;
  logic [1:0]          in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*DW-1:0] out_data;
  logic [SW-1:0]       out_sft;

  modport master (
    output in_valid, in_data, in_sft, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sft
  );

  modport slave (
    input  in_valid, in_data, in_sft, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sft
  );

endinterface

// File: rtl/pingpang_shift_stage.sv
// One registered conditional shift-down by STEP lanes; 1 cycle latency.
// Skid-free valid/ready: loads when empty or when downstream takes the held beat.
module pingpang_shift_stage
  import pingpang_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DW    = 8,
  parameter int STEP  = 1,
  localparam int SW        = sw_of(LANES),
  localparam int IN_LANES  = 2*LANES - STEP,
  localparam int OUT_LANES = 2*LANES - 2*STEP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [IN_LANES*DW-1:0]  in_w,
  input  logic [SW-1:0]           in_sft,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [OUT_LANES*DW-1:0] out_w,
  output logic [SW-1:0]           out_sft
);

  localparam int BIT = $clog2(STEP);

  logic [OUT_LANES*DW-1:0] nxt_w;

  // Later stages can shift by at most LANES-2*STEP more, so the top lanes are dropped here.
  always_comb begin
    nxt_w = in_w[0 +: OUT_LANES*DW];
    if (in_sft[BIT]) begin
      nxt_w = in_w[lane_lsb(STEP, DW) +: OUT_LANES*DW];
    end
  end

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_w   <= '0;
      out_sft <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_w   <= nxt_w;
        out_sft <= in_sft;
      end
    end
  end

endmodule

// File: rtl/pingpang_shift_pipe.sv
// Lane barrel shifter with zero/rotate/previous-beat fill; SW-cycle latency, 1 beat/clk.
// Per-stage valid/ready with bubble collapse; buffers SW beats before in_ready drops.
module pingpang_shift_pipe
  import pingpang_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pingpang_shift_pipe_if.slave bus
);

  localparam int SW = sw_of(LANES);

  // The top fill lane can never reach the output (max shift is LANES-1), so it is not kept.
  logic [(LANES-1)*DW-1:0]   prev_w;
  logic [(LANES-1)*DW-1:0]   fill_w;
  logic [(2*LANES-1)*DW-1:0] entry_w;
  logic                      accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    fill_w = '0;
    unique case (bus.in_mode)
      FILL_ZERO: fill_w = '0;
      FILL_ROT:  fill_w = bus.in_data[0 +: (LANES-1)*DW];
      FILL_PREV: fill_w = prev_w;
      default:   fill_w = '0;
    endcase
  end

  assign entry_w = {fill_w, bus.in_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_w <= '0;
    end else if (accept) begin
      prev_w <= bus.in_data[0 +: (LANES-1)*DW];
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_stg
    localparam int STEP = 1 << k;

    logic                           src_vld;
    logic                           src_rdy;
    logic [(2*LANES-STEP)*DW-1:0]   src_w;
    logic [SW-1:0]                  src_sft;
    logic                           dst_vld;
    logic                           dst_rdy;
    logic [(2*LANES-2*STEP)*DW-1:0] dst_w;
    logic [SW-1:0]                  dst_sft;

    if (k == 0) begin : g_head
      assign src_vld = bus.in_valid;
      assign src_w   = entry_w;
      assign src_sft = bus.in_sft;
    end else begin : g_link
      assign src_vld = g_stg[k-1].dst_vld;
      assign src_w   = g_stg[k-1].dst_w;
      assign src_sft = g_stg[k-1].dst_sft;
    end

    if (k == SW-1) begin : g_tail
      assign dst_rdy = bus.out_ready;
    end else begin : g_mid
      assign dst_rdy = g_stg[k+1].src_rdy;
    end

    pingpang_shift_stage #(
      .LANES (LANES),
      .DW    (DW),
      .STEP  (STEP)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .in_vld  (src_vld),
      .in_rdy  (src_rdy),
      .in_w    (src_w),
      .in_sft  (src_sft),
      .out_vld (dst_vld),
      .out_rdy (dst_rdy),
      .out_w   (dst_w),
      .out_sft (dst_sft)
    );
  end

  assign bus.in_ready  = g_stg[0].src_rdy;
  assign bus.out_valid = g_stg[SW-1].dst_vld;
  assign bus.out_data  = g_stg[SW-1].dst_w;
  assign bus.out_sft   = g_stg[SW-1].dst_sft;

endmodule

// File: tb/tb_pingpang_shift_pipe.sv
// Directed bench for the 16-lane, 8-bit pang shift pipeline with a beat scoreboard.
module tb_pingpang_shift_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pingpang_shift_pipe_if #(.LANES(16), .DW(8)) bus ();

  pingpang_shift_pipe #(.LANES(16), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [127:0] got_dat[$];
  logic [3:0]   got_sft[$];
  logic [127:0] exp_dat[$];
  logic [3:0]   exp_sft[$];
  logic [127:0] prev_m = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: output lane i is work-vector lane i+sft; work lanes 16..31 are the fill.
  function automatic logic [127:0] model(input logic [127:0] d, input int s,
                                         input logic [1:0] m, input logic [127:0] p);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      int j;
      logic [7:0] v;
      j = i + s;
      if (j < 16)        v = d[j*8 +: 8];
      else if (m == 2'b01) v = d[(j-16)*8 +: 8];
      else if (m == 2'b10) v = p[(j-16)*8 +: 8];
      else               v = 8'h00;
      r[i*8 +: 8] = v;
    end
    return r;
  endfunction

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      got_dat.push_back(bus.out_data);
      got_sft.push_back(bus.out_sft);
    end
  end

  task automatic clear_q();
    got_dat.delete(); got_sft.delete(); exp_dat.delete(); exp_sft.delete();
  endtask

  // Presents one beat (valid left high afterwards) and records the modelled result.
  task automatic send(input logic [127:0] d, input logic [3:0] s, input logic [1:0] m);
    bit ok;
    bit acc;
    ok = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sft = s; bus.in_mode = m;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) ok = 1;
    end
    chk("send_acc", 128'(ok), 128'd1);
    if (ok) begin
      exp_dat.push_back(model(d, int'(s), m, prev_m));
      exp_sft.push_back(s);
      prev_m = d;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_got(input string tag, input int n);
    for (int c = 0; c < 300 && got_dat.size() < n; c++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    chk(tag, 128'(got_dat.size()), 128'(n));
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [127:0] d, input logic [3:0] s);
    if (idx < got_dat.size()) begin
      chk({tag, "_dat"}, got_dat[idx], d);
      chk({tag, "_sft"}, 128'(got_sft[idx]), 128'(s));
    end else begin
      chk({tag, "_present"}, 128'(got_dat.size()), 128'(idx + 1));
    end
  endtask

  task automatic chk_sb(input string tag);
    for (int i = 0; i < exp_dat.size(); i++) chk_beat(tag, i, exp_dat[i], exp_sft[i]);
  endtask

  initial begin
    logic [127:0] e;
    logic [127:0] hold_d;
    logic [3:0]   hold_s;
    logic [127:0] r00;
    int lat;
    int n;
    bit acc;
    bit stream_done;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sft = '0; bus.in_mode = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
    chk("rst_out_sft", 128'(bus.out_sft), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1 reset = 1'b0;

    // Previous-beat fill: first beat after reset sees zeros, the second sees beat A.
    clear_q();
    send(ramp(8'h10), 4'd2, 2'b10);
    send(ramp(8'h20), 4'd2, 2'b10);
    idle();
    wait_got("prev_cnt", 2);
    e = '0;
    for (int i = 0; i < 14; i++) e[i*8 +: 8] = 8'h12 + 8'(i);
    chk_beat("prev_a", 0, e, 4'd2);
    for (int i = 0; i < 14; i++) e[i*8 +: 8] = 8'h22 + 8'(i);
    e[14*8 +: 8] = 8'h10; e[15*8 +: 8] = 8'h11;
    chk_beat("prev_b", 1, e, 4'd2);

    // Zero fill, sft=3, with latency measured from the accepting edge.
    clear_q();
    send(ramp(8'h00), 4'd3, 2'b00);
    idle();
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 128'(lat), 128'd4);
    wait_got("zero_cnt", 1);
    e = '0;
    for (int i = 0; i < 13; i++) e[i*8 +: 8] = 8'h03 + 8'(i);
    chk_beat("zero_s3", 0, e, 4'd3);

    // Rotate, sft=15.
    clear_q();
    send(ramp(8'h00), 4'd15, 2'b01);
    idle();
    wait_got("rot_cnt", 1);
    e = '0;
    e[7:0] = 8'h0F;
    for (int i = 1; i < 16; i++) e[i*8 +: 8] = 8'(i - 1);
    chk_beat("rot_s15", 0, e, 4'd15);

    // Identity at sft=0 in every mode, then reserved mode against zero fill at sft=5.
    clear_q();
    for (int m = 0; m < 4; m++) send(ramp(8'h40), 4'd0, 2'(m));
    send(ramp(8'h40), 4'd5, 2'b11);
    send(ramp(8'h40), 4'd5, 2'b00);
    idle();
    wait_got("ident_cnt", 6);
    for (int m = 0; m < 4; m++) chk_beat($sformatf("ident_m%0d", m), m, ramp(8'h40), 4'd0);
    e = '0;
    for (int i = 0; i < 11; i++) e[i*8 +: 8] = 8'h45 + 8'(i);
    chk_beat("rsvd_s5", 4, e, 4'd5);
    chk_beat("zero_s5", 5, e, 4'd5);
    r00 = (got_dat.size() > 5) ? got_dat[5] : '1;
    if (got_dat.size() > 4) chk("rsvd_vs_zero", got_dat[4], r00);

    // Random stream under a 1,0,0,1 out_ready pattern.
    clear_q();
    stream_done = 0;
    fork
      begin
        for (int b = 0; b < 20; b++)
          send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)));
        idle();
        stream_done = 1;
      end
      begin
        int c;
        c = 0;
        while (!stream_done) begin
          @(posedge clk); #1;
          c++;
          bus.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_got("stream_cnt", 20);
    chk_sb("stream");

    // Full stall: exactly SW beats are absorbed, output holds steady.
    clear_q();
    bus.out_ready = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = {$urandom, $urandom, $urandom, $urandom};
    bus.in_sft = 4'($urandom_range(0, 15)); bus.in_mode = 2'($urandom_range(0, 3));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        exp_dat.push_back(model(bus.in_data, int'(bus.in_sft), bus.in_mode, prev_m));
        exp_sft.push_back(bus.in_sft);
        prev_m = bus.in_data;
        n++;
        bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        bus.in_sft = 4'($urandom_range(0, 15)); bus.in_mode = 2'($urandom_range(0, 3));
      end
    end
    idle();
    chk("stall_acc", 128'(n), 128'd4);
    @(negedge clk);
    chk("stall_in_ready", 128'(bus.in_ready), 128'd0);
    hold_d = bus.out_data; hold_s = bus.out_sft;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_dat_hold", bus.out_data, hold_d);
    chk("stall_sft_hold", 128'(bus.out_sft), 128'(hold_s));
    chk("stall_first", bus.out_data, exp_dat[0]);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_got("stall_cnt", 4);
    chk_sb("stall");

    // Reset with three beats in flight.
    clear_q();
    bus.out_ready = 1'b0;
    send(ramp(8'h60), 4'd1, 2'b10);
    send(ramp(8'h70), 4'd2, 2'b01);
    send(ramp(8'h80), 4'd3, 2'b00);
    idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("pre_rst_valid", 128'(bus.out_valid), 128'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_async_data", bus.out_data, 128'd0);
    @(posedge clk); #1 reset = 1'b0;
    clear_q();
    prev_m = '0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale", 128'(got_dat.size()), 128'd0);
    send(ramp(8'h50), 4'd15, 2'b10);
    idle();
    wait_got("post_rst_cnt", 1);
    e = '0;
    e[7:0] = 8'h5F;
    chk_beat("post_rst_prev", 0, e, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
